uart_tx_fifo: RTL

Parametrised next-generation UART transmitter for the Segway serial links.
- Buffers outgoing words in an internal FIFO and sends them back-to-back with no idle gap.
- Frame format is configurable at elaboration: data width, optional even/odd parity, 1 or 2 stop bits.
- Sits between the command/telemetry logic and the TX pin; bit timing comes from a baud divider on the 50 MHz system clock.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_tx_fifo.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame-geometry helper for the UART transmit and receive paths.
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XMIT = 1'b1
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int frame_w(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: queued words leave back-to-back as start/data/parity/stop frames.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 2604,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         trmt,
    input  logic [DATA_BITS-1:0]         tx_data,
    output logic                         tx_rdy,
    output logic                         TX,
    output logic                         tx_busy,
    output logic                         tx_done,
    output logic                         tx_ovf,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_cnt
);

    localparam int FRAME_W = frame_w(DATA_BITS, PARITY, STOP_BITS);
    localparam int BCW     = $clog2(FRAME_W + 1);
    localparam int BAUD_W  = 12;

    tx_state_t           state_q, state_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BCW-1:0]      bit_q, bit_d;
    logic                done_q, done_d;
    logic                ovf_q;
    logic                load;
    logic                fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;
    logic [FRAME_W-1:0]  frame_word;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (trmt),
        .pop   (load),
        .wdata (tx_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    for (genvar gi = 0; gi < FRAME_W; gi++) begin : g_frame
        if (gi == 0) begin : g_start
            assign frame_word[gi] = 1'b0;
        end else if (gi <= DATA_BITS) begin : g_data
            assign frame_word[gi] = fifo_head[gi-1];
        end else if (gi == DATA_BITS + 1 && PARITY != PAR_NONE) begin : g_par
            assign frame_word[gi] = (^fifo_head) ^ (PARITY == PAR_ODD);
        end else begin : g_stop
            assign frame_word[gi] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        done_d  = done_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                load = !fifo_empty;
            end
            XMIT: begin
                if (baud_q == BAUD_W'(BAUD_DIV - 1)) begin
                    baud_d = '0;
                    if (bit_q == BCW'(FRAME_W - 1)) begin
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            shift_d = '1;
                            // A word arriving on this very edge reloads next cycle, so it is not an end of traffic.
                            done_d  = !(trmt && !fifo_full);
                        end
                    end else begin
                        shift_d = {1'b1, shift_q[FRAME_W-1:1]};
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = XMIT;
            shift_d = frame_word;
            baud_d  = '0;
            bit_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '1;
            baud_q  <= '0;
            bit_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            done_q  <= done_d;
            if (trmt && fifo_full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign TX      = shift_q[0];
    assign tx_busy = (state_q == XMIT);
    assign tx_done = done_q;
    assign tx_ovf  = ovf_q;
    assign tx_rdy  = !fifo_full;

endmodule
